// File: rtl/flash_seq.sv
// flash_seq: turns read/program/erase requests into flash_cms primitives.
// Define FLASH_SEQ_TIMEOUT_EN to give up after POLL_MAX busy status polls.
module flash_seq #(
  parameter int POLL_GAP = 64,
  parameter int POLL_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [7:0]  status,
  output logic [7:0]  eng_command,
  output logic [7:0]  eng_data_in,
  output logic [23:0] eng_address,
  output logic [7:0]  eng_numbyte,
  output logic        eng_valid_in,
  output logic        eng_last_in,
  input  logic        eng_ready_in,
  input  logic [7:0]  eng_data_out,
  input  logic        eng_valid,
  input  logic        eng_csbar
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN_ISSUE,
    S_WREN_WAIT,
    S_OP_ISSUE,
    S_OP_WAIT,
    S_POLL_ISSUE,
    S_POLL_WAIT,
    S_POLL_GAP,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_PP = 2'b01;

  if (POLL_GAP < 1 || POLL_MAX < 1) begin : g_bad_param
    $error("flash_seq: POLL_GAP and POLL_MAX must be >= 1");
  end

  state_t      state, state_nx;
  logic [1:0]  op_q;
  logic [23:0] addr_q;
  logic [7:0]  len_q;
  logic        seen_low;
  logic        err_q;
  logic        last_sent;
  logic [7:0]  byte_cnt;
  logic [7:0]  status_q;
  logic [15:0] gap_cnt;

  logic waiting, cmpl, wip, accept, bad_req;
  logic prog_en, rd_en, wr_fire, cnt_full;
  logic poll_busy, poll_out, gap_end;

  assign waiting = (state == S_WREN_WAIT) ||
                   (state == S_OP_WAIT) ||
                   (state == S_POLL_WAIT);
  // CSbar high again after having been seen low ends a primitive
  assign cmpl     = waiting && seen_low && eng_csbar;
  assign wip      = eng_valid ? eng_data_out[0] : status_q[0];
  assign accept   = (state == S_IDLE) && req_valid;
  assign bad_req  = (req_op == 2'b11) ||
                    ((req_op == OP_RD) && (req_len == 8'd0));
  assign prog_en  = (state == S_OP_WAIT) && (op_q == OP_PP) &&
                    !last_sent;
  assign rd_en    = (state == S_OP_WAIT) && (op_q == OP_RD);
  assign cnt_full = (byte_cnt == 8'hFF);
  assign wr_fire  = prog_en && wr_valid && eng_ready_in;
  assign poll_busy = (state == S_POLL_WAIT) && cmpl && wip;
  assign gap_end  = (gap_cnt == 16'(POLL_GAP - 1));

`ifdef FLASH_SEQ_TIMEOUT_EN
  logic [15:0] poll_cnt;

  assign poll_out = (poll_cnt == 16'(POLL_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) poll_cnt <= '0;
    else if (accept) poll_cnt <= '0;
    else if (poll_busy) poll_cnt <= poll_cnt + 16'd1;
  end
`else
  assign poll_out = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (bad_req) state_nx = S_DONE;
          else if (req_op == OP_RD) state_nx = S_OP_ISSUE;
          else state_nx = S_WREN_ISSUE;
        end
      end
      S_WREN_ISSUE: state_nx = S_WREN_WAIT;
      S_WREN_WAIT:  if (cmpl) state_nx = S_OP_ISSUE;
      S_OP_ISSUE:   state_nx = S_OP_WAIT;
      S_OP_WAIT: begin
        if (cmpl)
          state_nx = (op_q == OP_RD) ? S_DONE : S_POLL_ISSUE;
      end
      S_POLL_ISSUE: state_nx = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (cmpl) begin
          if (!wip || poll_out) state_nx = S_DONE;
          else state_nx = S_POLL_GAP;
        end
      end
      S_POLL_GAP:   if (gap_end) state_nx = S_POLL_ISSUE;
      S_DONE:       state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    eng_command = 8'h00;
    unique case (state)
      S_WREN_ISSUE: eng_command = 8'h06;
      S_POLL_ISSUE: eng_command = 8'h05;
      S_OP_ISSUE: begin
        unique case (op_q)
          OP_RD:   eng_command = 8'h03;
          OP_PP:   eng_command = 8'h02;
          default: eng_command = 8'h20;
        endcase
      end
      default: eng_command = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      seen_low  <= 1'b0;
      err_q     <= 1'b0;
      last_sent <= 1'b0;
      byte_cnt  <= '0;
      status_q  <= '0;
      gap_cnt   <= '0;
    end else begin
      state    <= state_nx;
      seen_low <= waiting && !cmpl && (seen_low || !eng_csbar);
      gap_cnt  <= (state == S_POLL_GAP) ? gap_cnt + 16'd1 : '0;
      if (accept) begin
        op_q      <= req_op;
        addr_q    <= req_addr;
        len_q     <= req_len;
        err_q     <= bad_req;
        byte_cnt  <= '0;
        last_sent <= 1'b0;
      end
      if ((state == S_POLL_WAIT) && eng_valid)
        status_q <= eng_data_out;
      // 256th byte without wr_last: engine is told last, op is flagged
      if (wr_fire) begin
        byte_cnt <= byte_cnt + 8'd1;
        if (wr_last || cnt_full) last_sent <= 1'b1;
        if (cnt_full && !wr_last) err_q <= 1'b1;
      end
      if (poll_busy && poll_out) err_q <= 1'b1;
    end
  end

  assign req_ready    = (state == S_IDLE);
  assign done         = (state == S_DONE);
  assign err          = (state == S_DONE) && err_q;
  assign status       = status_q;
  assign eng_address  = addr_q;
  assign eng_numbyte  = len_q;
  assign rd_valid     = rd_en && eng_valid;
  assign rd_data      = rd_en ? eng_data_out : 8'h00;
  assign wr_ready     = prog_en && eng_ready_in;
  assign eng_valid_in = prog_en && wr_valid;
  assign eng_data_in  = prog_en ? wr_data : 8'h00;
  assign eng_last_in  = prog_en && (wr_last || cnt_full);

endmodule

// File: doc/flash_seq.md
# flash_seq

Operation sequencer for the `flash_cms` SPI command engine. It accepts high-level requests (read, page program, sector erase) and issues the primitive command sequence:

- READ_DATA alone for reads.
- WRITE_ENABLE, then the operation, then READ_STATUS polling until WIP clears, for program and erase.

It sits between the MCU bus glue and `flash_cms`, owns that engine exclusively, and detects engine completion from the chip-select line.

## Interface
Parameters:
- POLL_GAP, 64: idle clocks between status polls (≥1).
- POLL_MAX, 65535: polls before timeout (only with timeout compiled in).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high in IDLE only.
- req_op  in  2  00 read, 01 page program, 10 sector erase, 11 reserved.
- req_addr  in  24  flash byte address.
- req_len  in  8  read byte count (1..255); ignored otherwise.
- wr_data  in  8  program byte.
- wr_valid  in  1  program byte strobe.
- wr_last  in  1  final program byte.
- wr_ready  out  1  byte accepted when wr_valid&wr_ready.
- rd_data  out  8  read byte.
- rd_valid  out  1  one-cycle read-byte strobe.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done.
- status  out  8  last status register byte read.
- eng_command  out  8  to engine `command`.
- eng_data_in  out  8  to engine `data_in`.
- eng_address  out  24  to engine `address`.
- eng_numbyte  out  8  to engine `numByte_read`.
- eng_valid_in  out  1  to engine `valid_in`.
- eng_last_in  out  1  to engine `last_in`.
- eng_ready_in  in  1  from engine `ready_in`.
- eng_data_out  in  8  from engine `data_out`.
- eng_valid  in  1  from engine `valid`.
- eng_csbar  in  1  engine CSbar, monitored.

## Operation
- Reset: state IDLE. All outputs 0 except req_ready=1. status=8'h00.
- Request latch: on accept, req_op, req_addr and req_len are latched and held on eng_address/eng_numbyte until done.
- Command issue (`ISSUE_x` states): eng_command = opcode for exactly one cycle, then 8'h00. The engine starts on that return to zero.
- Command wait (`WAIT_x` states): set a `seen_low` flag when eng_csbar=0. A rising edge of eng_csbar with `seen_low` set marks the primitive complete; clear the flag.
- State flow:
  - IDLE → WREN_ISSUE for program/erase; → OP_ISSUE for read.
  - WREN_ISSUE(06) → WREN_WAIT → OP_ISSUE.
  - OP_ISSUE(03/02/20) → OP_WAIT.
  - OP_WAIT: read → DONE; program/erase → POLL_ISSUE.
  - POLL_ISSUE(05) → POLL_WAIT. On completion, status is captured from the eng_valid byte. WIP (bit0)=1 → POLL_GAP; WIP=0 → DONE.
  - POLL_GAP counts POLL_GAP clocks, then → POLL_ISSUE.
  - DONE: pulse done for one cycle → IDLE.
- Read: in OP_WAIT, rd_data/rd_valid = eng_data_out/eng_valid. Exactly req_len strobes occur.
- Program forwarding: in OP_WAIT only (combinational):
  - wr_ready = eng_ready_in
  - eng_valid_in = wr_valid
  - eng_data_in = wr_data
  - eng_last_in = wr_last | (byte count == 255)
- Page overflow: an 8-bit byte counter tracks program bytes. If the 256th byte lacks wr_last, last is forced and err is set at done.
- Errors (done+err next cycle, no engine activity): req_op=11, or read with req_len=0.
- Outside OP_WAIT: wr_ready=0, eng_valid_in=0.

## Timing
- Accept at cycle T. eng_command is nonzero at T+1 only and 0 at T+2.
- done asserts the cycle after the final eng_csbar rising edge, or after the WIP=0 status capture. req_ready returns the cycle after done.
- Between primitives, the next ISSUE begins the cycle after a completion edge.
- A req_valid held during a busy period is ignored until IDLE.
- Reset mid-operation: IDLE next cycle, eng_command=0. The engine must share rst.

## Configuration
- FLASH_SEQ_TIMEOUT_EN defined: a 16-bit poll counter runs. After POLL_MAX polls with WIP=1, go to DONE with err=1; status holds the last byte.
- Undefined: polling continues indefinitely. The counter is absent, and err is never set by polling.

## Test plan
- Read: op=00, addr=24'h000100, len=4, engine model returns A1 A2 A3 B4 → four rd_valid strobes in order, eng_command sequence 03 then 00, done=1, err=0.
- Erase: op=10, addr=24'h001000, status model returns 03,03,00 → commands 06, 20, 05×3; ≥POLL_GAP idle clocks between polls; status=8'h00; done, err=0.
- Program: op=01, three bytes 11,22,33 with wr_last on 33 → eng_last_in=1 on the third byte only, then polling; done, err=0.
- Overflow: program 256 bytes without wr_last → eng_last_in forced on byte 256, wr_ready=0 afterwards, done with err=1.
- Errors: op=11 → done+err at T+1 with no command issued. Read with len=0 → same response.
- Timeout (FLASH_SEQ_TIMEOUT_EN, POLL_MAX=4): status always 01 → exactly 4 polls, then done with err=1 and status=8'h01. Reset asserted mid-poll → req_ready=1 and eng_command=0 the next cycle.
